// File: rtl/wb_dual_write_sequencer.sv
// ----------------------------------------------------------------------------
// wb_dual_write_sequencer
//
// Purpose:
//   Writeback-stage controller that serializes instructions producing two
//   register results (long multiply, load with base writeback, ...) onto a
//   single register-file write port. The primary result retires in the first
//   cycle while the pipeline is stalled. The secondary result is held in a
//   pending register and retires in the following cycle. The pending write is
//   exposed so the EXE-stage forwarding unit can source it.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   wb_valid             WB stage holds a valid instruction
//   wb_we/dest/val       primary write request
//   wb_we2/dest2/val2    secondary write request
//   rf_we/waddr/wdata    register-file write port (combinational)
//   stall                freeze IF..WB pipeline registers (combinational)
//   pend_valid/dest/val  held second write not yet retired (registered)
//   dual_count           split retirements since reset, wraps (registered)
// ----------------------------------------------------------------------------
module wb_dual_write_sequencer #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_valid,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_dest,
    input  logic [DATA_W-1:0] wb_val,
    input  logic              wb_we2,
    input  logic [ADDR_W-1:0] wb_dest2,
    input  logic [DATA_W-1:0] wb_val2,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              stall,
    output logic              pend_valid,
    output logic [ADDR_W-1:0] pend_dest,
    output logic [DATA_W-1:0] pend_val,
    output logic [CNT_W-1:0]  dual_count
);

    typedef enum logic {
        IDLE,
        SECOND
    } state_t;

    state_t state;
    state_t state_next;

    // Two distinct destinations need two write-port cycles; a matching
    // destination pair collapses to one write where the secondary wins.
    logic is_dual;
    assign is_dual = wb_valid & wb_we & wb_we2 & (wb_dest != wb_dest2);

    // State register, pending second write and split-retirement counter.
    // The counter is bumped on the cycle the dual instruction is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pend_valid <= 1'b0;
            pend_dest  <= '0;
            pend_val   <= '0;
            dual_count <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && is_dual) begin
                pend_valid <= 1'b1;
                pend_dest  <= wb_dest2;
                pend_val   <= wb_val2;
                dual_count <= dual_count + 1'b1;
            end else if (state == SECOND) begin
                pend_valid <= 1'b0;
            end
        end
    end

    // Next-state and write-port steering. Reset forces the port idle so a
    // pending write caught by reset is dropped rather than retired. SECOND
    // never asserts stall, so stall cannot be high on consecutive cycles.
    always_comb begin
        state_next = state;
        rf_we      = 1'b0;
        rf_waddr   = '0;
        rf_wdata   = '0;
        stall      = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (is_dual) begin
                        rf_we      = 1'b1;
                        rf_waddr   = wb_dest;
                        rf_wdata   = wb_val;
                        stall      = 1'b1;
                        state_next = SECOND;
                    end else if (wb_valid && wb_we2) begin
                        rf_we    = 1'b1;
                        rf_waddr = wb_dest2;
                        rf_wdata = wb_val2;
                    end else if (wb_valid && wb_we) begin
                        rf_we    = 1'b1;
                        rf_waddr = wb_dest;
                        rf_wdata = wb_val;
                    end
                end
                SECOND: begin
                    rf_we      = 1'b1;
                    rf_waddr   = pend_dest;
                    rf_wdata   = pend_val;
                    state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_dual_write_sequencer.sv
// ----------------------------------------------------------------------------
// tb_wb_dual_write_sequencer
//
// Directed bench for wb_dual_write_sequencer. Inputs change on the falling
// edge; combinational outputs are sampled 1ns later and registered outputs
// are sampled on the falling edge after the rising edge that updates them.
// A second instance with CNT_W=2 shares the stimulus to exercise wrapping.
// ----------------------------------------------------------------------------
module tb_wb_dual_write_sequencer;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;
    localparam int CNT_W  = 16;

    logic              clk;
    logic              rst;
    logic              wb_valid;
    logic              wb_we;
    logic [ADDR_W-1:0] wb_dest;
    logic [DATA_W-1:0] wb_val;
    logic              wb_we2;
    logic [ADDR_W-1:0] wb_dest2;
    logic [DATA_W-1:0] wb_val2;

    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              stall;
    logic              pend_valid;
    logic [ADDR_W-1:0] pend_dest;
    logic [DATA_W-1:0] pend_val;
    logic [CNT_W-1:0]  dual_count;

    logic              rf_we_n;
    logic [ADDR_W-1:0] rf_waddr_n;
    logic [DATA_W-1:0] rf_wdata_n;
    logic              stall_n;
    logic              pend_valid_n;
    logic [ADDR_W-1:0] pend_dest_n;
    logic [DATA_W-1:0] pend_val_n;
    logic [1:0]        dual_count_n;

    int checks;
    int errors;
    int exp_count;

    wb_dual_write_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .wb_valid(wb_valid),
        .wb_we(wb_we), .wb_dest(wb_dest), .wb_val(wb_val),
        .wb_we2(wb_we2), .wb_dest2(wb_dest2), .wb_val2(wb_val2),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .stall(stall),
        .pend_valid(pend_valid), .pend_dest(pend_dest), .pend_val(pend_val),
        .dual_count(dual_count)
    );

    wb_dual_write_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(2)) dut_narrow (
        .clk(clk), .rst(rst), .wb_valid(wb_valid),
        .wb_we(wb_we), .wb_dest(wb_dest), .wb_val(wb_val),
        .wb_we2(wb_we2), .wb_dest2(wb_dest2), .wb_val2(wb_val2),
        .rf_we(rf_we_n), .rf_waddr(rf_waddr_n), .rf_wdata(rf_wdata_n), .stall(stall_n),
        .pend_valid(pend_valid_n), .pend_dest(pend_dest_n), .pend_val(pend_val_n),
        .dual_count(dual_count_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic we, input logic [3:0] d, input logic [31:0] val,
                         input logic we2, input logic [3:0] d2, input logic [31:0] val2);
        wb_valid = v;  wb_we = we;  wb_dest = d;  wb_val = val;
        wb_we2 = we2;  wb_dest2 = d2;  wb_val2 = val2;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, 1'b1, 4'd2, 32'h1, 1'b1, 4'd3, 32'h2);
        #1;
        checks++;
        if ({rf_we, stall} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reset_port: rf_we/stall=%b required 00", {rf_we, stall});
        end
        @(negedge clk);
        checks++;
        if ({pend_valid, pend_dest, pend_val, dual_count} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_regs: pend_valid=%b pend_dest=%0d pend_val=%h count=%0d required all 0",
                     pend_valid, pend_dest, pend_val, dual_count);
        end
        rst = 1'b0;
        drive(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
        exp_count = 0;
    endtask

    task automatic test_single();
        // Primary only
        @(negedge clk);
        drive(1'b1, 1'b1, 4'd3, 32'h11, 1'b0, 4'd6, 32'h66);
        #1;
        checks++;
        if ({rf_we, rf_waddr, rf_wdata, stall} !== {1'b1, 4'd3, 32'h11, 1'b0}) begin
            errors++;
            $display("[TB] FAIL single_primary: we=%b addr=%0d data=%h stall=%b required 1 3 11 0",
                     rf_we, rf_waddr, rf_wdata, stall);
        end
        // Secondary only
        @(negedge clk);
        drive(1'b1, 1'b0, 4'd3, 32'h11, 1'b1, 4'd6, 32'h66);
        #1;
        checks++;
        if ({rf_we, rf_waddr, rf_wdata, stall} !== {1'b1, 4'd6, 32'h66, 1'b0}) begin
            errors++;
            $display("[TB] FAIL single_secondary: we=%b addr=%0d data=%h stall=%b required 1 6 66 0",
                     rf_we, rf_waddr, rf_wdata, stall);
        end
        // Enables set but wb_valid low
        @(negedge clk);
        drive(1'b0, 1'b1, 4'd3, 32'h11, 1'b1, 4'd6, 32'h66);
        #1;
        checks++;
        if ({rf_we, rf_waddr, rf_wdata, stall} !== {1'b0, 4'd0, 32'h0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL invalid_idle: we=%b addr=%0d data=%h stall=%b required 0 0 0 0",
                     rf_we, rf_waddr, rf_wdata, stall);
        end
        // Same destination: secondary wins, no stall
        @(negedge clk);
        drive(1'b1, 1'b1, 4'd7, 32'h1, 1'b1, 4'd7, 32'h2);
        #1;
        checks++;
        if ({rf_we, rf_waddr, rf_wdata, stall} !== {1'b1, 4'd7, 32'h2, 1'b0}) begin
            errors++;
            $display("[TB] FAIL same_dest: we=%b addr=%0d data=%h stall=%b required 1 7 2 0",
                     rf_we, rf_waddr, rf_wdata, stall);
        end
        @(negedge clk);
        drive(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
        checks++;
        if ({pend_valid, dual_count} !== {1'b0, 16'd0}) begin
            errors++;
            $display("[TB] FAIL single_count: pend_valid=%b count=%0d required 0 0", pend_valid, dual_count);
        end
    endtask

    task automatic test_dual();
        @(negedge clk);
        drive(1'b1, 1'b1, 4'd2, 32'hAAAA, 1'b1, 4'd5, 32'h5555);
        #1;
        checks++;
        if ({rf_we, rf_waddr, rf_wdata, stall} !== {1'b1, 4'd2, 32'hAAAA, 1'b1}) begin
            errors++;
            $display("[TB] FAIL dual_cycle0: we=%b addr=%0d data=%h stall=%b required 1 2 aaaa 1",
                     rf_we, rf_waddr, rf_wdata, stall);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({pend_valid, pend_dest, pend_val} !== {1'b1, 4'd5, 32'h5555}) begin
            errors++;
            $display("[TB] FAIL dual_pend: valid=%b dest=%0d val=%h required 1 5 5555",
                     pend_valid, pend_dest, pend_val);
        end
        checks++;
        if ({rf_we, rf_waddr, rf_wdata, stall} !== {1'b1, 4'd5, 32'h5555, 1'b0}) begin
            errors++;
            $display("[TB] FAIL dual_cycle1: we=%b addr=%0d data=%h stall=%b required 1 5 5555 0",
                     rf_we, rf_waddr, rf_wdata, stall);
        end
        drive(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
        exp_count++;
        @(negedge clk);
        checks++;
        if ({pend_valid, pend_dest, dual_count, rf_we, stall} !== {1'b0, 4'd5, exp_count[15:0], 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL dual_cycle2: pend_valid=%b pend_dest=%0d count=%0d we=%b stall=%b required 0 5 %0d 0 0",
                     pend_valid, pend_dest, dual_count, rf_we, stall, exp_count);
        end
    endtask

    // Three back-to-back duals, including register 0 as a primary target.
    task automatic test_back_to_back();
        logic [3:0]  d  [3];
        logic [3:0]  d2 [3];
        logic [31:0] v  [3];
        logic [31:0] v2 [3];
        d  = '{4'd0, 4'd8, 4'd12};
        d2 = '{4'd1, 4'd9, 4'd13};
        v  = '{32'h1000, 32'h2000, 32'h3000};
        v2 = '{32'h1001, 32'h2001, 32'h3001};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(1'b1, 1'b1, d[i], v[i], 1'b1, d2[i], v2[i]);
            #1;
            checks++;
            if ({rf_we, rf_waddr, rf_wdata, stall} !== {1'b1, d[i], v[i], 1'b1}) begin
                errors++;
                $display("[TB] FAIL b2b_primary%0d: we=%b addr=%0d data=%h stall=%b required 1 %0d %h 1",
                         i, rf_we, rf_waddr, rf_wdata, stall, d[i], v[i]);
            end
            @(negedge clk);
            #1;
            checks++;
            if ({rf_we, rf_waddr, rf_wdata, stall} !== {1'b1, d2[i], v2[i], 1'b0}) begin
                errors++;
                $display("[TB] FAIL b2b_secondary%0d: we=%b addr=%0d data=%h stall=%b required 1 %0d %h 0",
                         i, rf_we, rf_waddr, rf_wdata, stall, d2[i], v2[i]);
            end
            exp_count++;
        end
        drive(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
        @(negedge clk);
        checks++;
        if ({pend_valid, dual_count} !== {1'b0, exp_count[15:0]}) begin
            errors++;
            $display("[TB] FAIL b2b_count: pend_valid=%b count=%0d required 0 %0d", pend_valid, dual_count, exp_count);
        end
    endtask

    task automatic test_reset_in_second();
        @(negedge clk);
        drive(1'b1, 1'b1, 4'd4, 32'hBEEF, 1'b1, 4'd9, 32'h9999);
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rst2_stall: stall=%b required 1", stall);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({rf_we, stall} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL rst2_no_write: we=%b addr=%0d stall=%b required we 0 stall 0",
                     rf_we, rf_waddr, stall);
        end
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
        exp_count = 0;
        #1;
        checks++;
        if ({pend_valid, stall, rf_we, dual_count} !== {1'b0, 1'b0, 1'b0, 16'd0}) begin
            errors++;
            $display("[TB] FAIL rst2_after: pend_valid=%b stall=%b we=%b count=%0d required 0 0 0 0",
                     pend_valid, stall, rf_we, dual_count);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive(1'b1, 1'b1, 4'd10, 32'(i), 1'b1, 4'd11, 32'(i + 100));
            @(negedge clk);
            exp_count++;
        end
        drive(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
        @(negedge clk);
        checks++;
        if (dual_count !== 16'd5) begin
            errors++;
            $display("[TB] FAIL wrap_wide: count=%0d required 5", dual_count);
        end
        checks++;
        if (dual_count_n !== 2'd1) begin
            errors++;
            $display("[TB] FAIL wrap_narrow: count=%0d required 1", dual_count_n);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        exp_count = 0;
        rst = 1'b1;
        drive(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
        test_reset();
        test_single();
        test_dual();
        test_back_to_back();
        test_reset_in_second();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
